lc_transition_ctrl: RTL and testbench
=====================================

// Module: lc_transition_ctrl
// PURPOSE
//  Parametrised lifecycle (LC) controller. Holds the current LC state and authenticates
//  transition requests against a per-state golden owner signature fetched from an external LC memory.
//  Adds the following over the fixed 6-state controller:
//  - targeted or skip-ahead transitions
//  - read timeout
//  - failed-attempt lockout
//  - an asset-scrub pulse on every state change
//  Sits between the host/security mailbox and the LC signature memory.
// PARAMETERS
//  ID_WIDTH     `LC_MEMORY_WIDTH   identifier / signature width
//  NUM_STATES   6                  number of LC states; state NUM_STATES-1 = end-of-life (EOL)
//  STATE_W      $clog2(NUM_STATES) LC state encoding width (derived, do not override)
//  RESET_STATE  1                  lc_state value after reset
//  ALLOW_SKIP   0                  1: any target > lc_state is legal; 0: only lc_state+1 is legal
//  MAX_FAIL     3                  consecutive BAD_ID failures before permanent lock (>=1)
//  RD_TIMEOUT   16                 cycles to wait for mem_valid before TIMEOUT (>=1)
// PORTS
//  clk          in   1         clock
//  rst          in   1         asynchronous reset, active-high
//  req          in   1         transition request, level; held until done seen
//  req_target   in   STATE_W   requested next LC state
//  req_id       in   ID_WIDTH  requester identifier
//  mem_rd_en    out  1         signature read enable
//  mem_addr     out  STATE_W   signature address (= lc_state)
//  mem_rd_data  in   ID_WIDTH  golden signature
//  mem_valid    in   1         mem_rd_data valid
//  done         out  1         request complete; held until req low
//  success      out  1         transition performed; qualified by done
//  err_code     out  3         0 OK, 1 BAD_ID, 2 BAD_TARGET, 3 EOL, 4 TIMEOUT, 5 LOCKED
//  lc_state     out  STATE_W   current LC state
//  lc_changed   out  1         1-cycle pulse when lc_state updates (asset scrub trigger)
//  locked       out  1         lockout active; sticky until rst
// BEHAVIOUR
//  Reset values:
//  - lc_state = RESET_STATE
//  - all other outputs = 0
//  - fail_cnt = 0; id register = 0
//  - FSM = IDLE
//  - rst mid-operation aborts any request; no partial state update.
//  FSM states: IDLE, READ, DONE.
//  IDLE, req=1 sampled: latch req_id and req_target, then evaluate in priority order:
//  - locked: go to DONE, err=5
//  - lc_state==NUM_STATES-1: go to DONE, err=3
//  - target illegal (target<=lc_state, target>=NUM_STATES, or ALLOW_SKIP=0 and target!=lc_state+1): go to DONE, err=2
//  - otherwise: go to READ; mem_rd_en=1 and mem_addr=lc_state from the next cycle.
//  READ:
//  - mem_rd_en held high; the timeout counter counts cycles in READ.
//  - mem_valid=1 and data==id:
//    - lc_state<=target; lc_changed=1 for exactly 1 cycle
//    - success=1, err=0; fail_cnt<=0
//    - go to DONE
//  - mem_valid=1 and data!=id:
//    - err=1; fail_cnt+1
//    - fail_cnt reaching MAX_FAIL sets locked the same edge
//    - go to DONE
//  - counter reaches RD_TIMEOUT without mem_valid: err=4, go to DONE. fail_cnt unchanged.
//  - mem_rd_en drops on the same edge that enters DONE. The latched id is zeroed on that edge in every outcome.
//  DONE:
//  - done/success/err_code remain stable while req=1.
//  - On req=0 sampled: clear done/success/err_code and go to IDLE.
//  - A new request needs req low for at least 1 cycle.
//  Latency for a successful request: done rises 1 cycle after the mem_valid sample. Early rejections: done 1 cycle after req sampled.
//  mem_valid outside READ is ignored. lc_state never decreases and never exceeds NUM_STATES-1. lc_state is frozen while locked.
// TESTING
//  - Reset, lc_state=1, req target=2 with correct id, valid after 3 cycles -> done, success=1, lc_state=2, one lc_changed pulse.
//  - ALLOW_SKIP=0: target=4 from state 2 -> err=2 with no mem_rd_en assertion. ALLOW_SKIP=1: same request succeeds, lc_state=4.
//  - 3 requests with wrong id -> err=1 each, locked=1 after the 3rd. Correct id next -> err=5. rst -> locked=0, lc_state=1.
//  - mem_valid never asserted -> err=4 after exactly 16 READ cycles. fail_cnt unchanged; lc_state unchanged.
//  - lc_state=5 (EOL) with any request -> err=3, success=0. Hold req 10 cycles -> done stays 1 until req drops.
//  - rst asserted in READ with mem_valid pending -> all outputs at reset values, no lc_changed pulse.

Source files
------------

// File: rtl/lc_transition_ctrl.sv
// Lifecycle transition controller: authenticates requests to move lc_state forward against a
// per-state golden signature read from LC memory, with read timeout and failed-attempt lockout.
`ifndef LC_MEMORY_WIDTH
`define LC_MEMORY_WIDTH 32
`endif

module lc_transition_ctrl #(
    parameter int ID_WIDTH    = `LC_MEMORY_WIDTH,
    parameter int NUM_STATES  = 6,
    parameter int STATE_W     = $clog2(NUM_STATES),
    parameter int RESET_STATE = 1,
    parameter bit ALLOW_SKIP  = 1'b0,
    parameter int MAX_FAIL    = 3,
    parameter int RD_TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [STATE_W-1:0]  req_target,
    input  logic [ID_WIDTH-1:0] req_id,
    output logic                mem_rd_en,
    output logic [STATE_W-1:0]  mem_addr,
    input  logic [ID_WIDTH-1:0] mem_rd_data,
    input  logic                mem_valid,
    output logic                done,
    output logic                success,
    output logic [2:0]          err_code,
    output logic [STATE_W-1:0]  lc_state,
    output logic                lc_changed,
    output logic                locked
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);

    localparam logic [2:0] ERR_OK         = 3'd0;
    localparam logic [2:0] ERR_BAD_ID     = 3'd1;
    localparam logic [2:0] ERR_BAD_TARGET = 3'd2;
    localparam logic [2:0] ERR_EOL        = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
    localparam logic [2:0] ERR_LOCKED     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } fsm_t;

    fsm_t                state_q, state_d;
    logic [STATE_W-1:0]  lc_state_q, lc_state_d;
    logic [STATE_W-1:0]  target_q, target_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                done_q, done_d;
    logic                success_q, success_d;
    logic [2:0]          err_q, err_d;
    logic                lc_changed_q, lc_changed_d;
    logic                locked_q, locked_d;
    logic                target_ok;

    // Forward-only target check; the skip option only widens which forward targets pass.
    always_comb begin
        target_ok = 1'b1;
        if (int'(req_target) <= int'(lc_state_q)) begin
            target_ok = 1'b0;
        end
        if (int'(req_target) >= NUM_STATES) begin
            target_ok = 1'b0;
        end
        if (!ALLOW_SKIP && (int'(req_target) != int'(lc_state_q) + 1)) begin
            target_ok = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        lc_state_d   = lc_state_q;
        target_d     = target_q;
        id_d         = id_q;
        fail_cnt_d   = fail_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        mem_rd_en_d  = mem_rd_en_q;
        done_d       = done_q;
        success_d    = success_q;
        err_d        = err_q;
        lc_changed_d = 1'b0;
        locked_d     = locked_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (locked_q) begin
                        err_d = ERR_LOCKED;
                    end else if (int'(lc_state_q) == NUM_STATES - 1) begin
                        err_d = ERR_EOL;
                    end else if (!target_ok) begin
                        err_d = ERR_BAD_TARGET;
                    end else begin
                        state_d     = ST_READ;
                        done_d      = 1'b0;
                        id_d        = req_id;
                        target_d    = req_target;
                        tmo_cnt_d   = '0;
                        mem_rd_en_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (mem_valid) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    mem_rd_en_d = 1'b0;
                    id_d        = '0;
                    if (mem_rd_data == id_q) begin
                        lc_state_d   = target_q;
                        lc_changed_d = 1'b1;
                        success_d    = 1'b1;
                        err_d        = ERR_OK;
                        fail_cnt_d   = '0;
                    end else begin
                        err_d      = ERR_BAD_ID;
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        if (int'(fail_cnt_q) + 1 >= MAX_FAIL) begin
                            locked_d = 1'b1;
                        end
                    end
                end else if (int'(tmo_cnt_q) == RD_TIMEOUT - 1) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    mem_rd_en_d = 1'b0;
                    id_d        = '0;
                    err_d       = ERR_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b0;
                    success_d = 1'b0;
                    err_d     = ERR_OK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lc_state_q   <= STATE_W'(RESET_STATE);
            target_q     <= '0;
            id_q         <= '0;
            fail_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            mem_rd_en_q  <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            err_q        <= ERR_OK;
            lc_changed_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lc_state_q   <= lc_state_d;
            target_q     <= target_d;
            id_q         <= id_d;
            fail_cnt_q   <= fail_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mem_rd_en_q  <= mem_rd_en_d;
            done_q       <= done_d;
            success_q    <= success_d;
            err_q        <= err_d;
            lc_changed_q <= lc_changed_d;
            locked_q     <= locked_d;
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = lc_state_q;
    assign done       = done_q;
    assign success    = success_q;
    assign err_code   = err_q;
    assign lc_state   = lc_state_q;
    assign lc_changed = lc_changed_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// Directed bench: one controller without skip (dut0) and one with skip (dut1) share the memory bus.
module tb_lc_transition_ctrl;

    localparam int IDW = 16;
    localparam int SW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [SW-1:0]  req_target = '0;
    logic [IDW-1:0] req_id = '0;
    logic [IDW-1:0] mem_rd_data = '0;
    logic           mem_valid = 1'b0;

    logic           rd_en0, rd_en1, done0, done1, succ0, succ1, chg0, chg1, lock0, lock1;
    logic [SW-1:0]  addr0, addr1, st0, st1;
    logic [2:0]     err0, err1;

    int sel = 0;
    int total = 0;
    int bad = 0;

    int r_err, r_succ, r_lat, r_rd, r_pulses, r_addr, r_hold_ok;

    always #5 clk = ~clk;

    lc_transition_ctrl #(.ID_WIDTH(IDW), .NUM_STATES(6), .ALLOW_SKIP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .req_target(req_target), .req_id(req_id),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(mem_rd_data), .mem_valid(mem_valid),
        .done(done0), .success(succ0), .err_code(err0), .lc_state(st0),
        .lc_changed(chg0), .locked(lock0)
    );

    lc_transition_ctrl #(.ID_WIDTH(IDW), .NUM_STATES(6), .ALLOW_SKIP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_target(req_target), .req_id(req_id),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(mem_rd_data), .mem_valid(mem_valid),
        .done(done1), .success(succ1), .err_code(err1), .lc_state(st1),
        .lc_changed(chg1), .locked(lock1)
    );

    wire           rd_en_s = (sel != 0) ? rd_en1 : rd_en0;
    wire [SW-1:0]  addr_s  = (sel != 0) ? addr1  : addr0;
    wire           done_s  = (sel != 0) ? done1  : done0;
    wire           succ_s  = (sel != 0) ? succ1  : succ0;
    wire [2:0]     err_s   = (sel != 0) ? err1   : err0;
    wire           chg_s   = (sel != 0) ? chg1   : chg0;

    function automatic logic [IDW-1:0] gold(input int s);
        return 16'hA500 + IDW'(s * 16'h0013);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One request: vdelay = read-enable cycles before mem_valid (0 = never), hold = extra cycles req stays high after done.
    task automatic run_req(input int sel_i, input int tgt, input logic good, input int vdelay, input int hold);
        bit seen;
        sel = sel_i;
        r_err = -1; r_succ = -1; r_lat = -1; r_rd = 0; r_pulses = 0; r_addr = -1; r_hold_ok = 1;
        seen = 1'b0;
        @(negedge clk);
        req_target = SW'(tgt);
        req_id = gold(tgt);
        if (sel_i != 0) req1 = 1'b1; else req0 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (chg_s) r_pulses++;
            if (done_s) begin
                r_lat = k; r_err = int'(err_s); r_succ = int'(succ_s); seen = 1'b1;
                break;
            end
            mem_valid = 1'b0;
            if (rd_en_s) begin
                r_rd++;
                if (r_rd == 1) r_addr = int'(addr_s);
                if (vdelay > 0 && r_rd == vdelay) begin
                    mem_valid = 1'b1;
                    mem_rd_data = good ? gold(tgt) : ~gold(tgt);
                end
            end
        end
        mem_valid = 1'b0;
        if (!seen) check("done_bound", 0, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (chg_s) r_pulses++;
            if (!done_s || int'(err_s) != r_err || int'(succ_s) != r_succ) r_hold_ok = 0;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("done_clear", int'(done_s), 0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state0", int'(st0), 1);
        check("rst_state1", int'(st1), 1);
        check("rst_done", int'(done0), 0);
        check("rst_err", int'(err0), 0);
        check("rst_rden", int'(rd_en0), 0);
        check("rst_lock", int'(lock0), 0);

        // Successful 1 -> 2 with valid on the third read cycle
        run_req(0, 2, 1'b1, 3, 2);
        check("ok_err", r_err, 0);
        check("ok_succ", r_succ, 1);
        check("ok_lat", r_lat, 3);
        check("ok_addr", r_addr, 1);
        check("ok_pulses", r_pulses, 1);
        check("ok_state", int'(st0), 2);

        // Skip 2 -> 4 rejected without a memory read
        run_req(0, 4, 1'b1, 3, 0);
        check("skip0_err", r_err, 2);
        check("skip0_rd", r_rd, 0);
        check("skip0_lat", r_lat, 0);
        check("skip0_state", int'(st0), 2);

        // Same request on the skip-enabled controller
        run_req(1, 2, 1'b1, 1, 0);
        check("s1_step_state", int'(st1), 2);
        run_req(1, 4, 1'b1, 2, 0);
        check("skip1_err", r_err, 0);
        check("skip1_succ", r_succ, 1);
        check("skip1_state", int'(st1), 4);
        run_req(1, 4, 1'b1, 2, 0);
        check("backward_err", r_err, 2);

        // Three bad ids lock the controller
        for (int i = 0; i < 3; i++) begin
            run_req(0, 3, 1'b0, 2, 0);
            check("badid_err", r_err, 1);
            check("badid_lock", int'(lock0), (i == 2) ? 1 : 0);
        end
        run_req(0, 3, 1'b1, 2, 0);
        check("locked_err", r_err, 5);
        check("locked_rd", r_rd, 0);
        check("locked_state", int'(st0), 2);
        pulse_rst();
        check("unlock", int'(lock0), 0);
        check("unlock_state", int'(st0), 1);

        // Timeout after exactly 16 read cycles
        run_req(0, 2, 1'b1, 0, 0);
        check("tmo_err", r_err, 4);
        check("tmo_rd", r_rd, 16);
        check("tmo_lat", r_lat, 16);
        check("tmo_state", int'(st0), 1);

        // Timeout must leave the failure count alone
        run_req(0, 2, 1'b0, 1, 0);
        run_req(0, 2, 1'b0, 1, 0);
        run_req(0, 2, 1'b1, 0, 0);
        check("tmo_cnt_err", r_err, 4);
        check("tmo_nolock", int'(lock0), 0);
        run_req(0, 2, 1'b0, 1, 0);
        check("third_lock", int'(lock0), 1);
        pulse_rst();

        // EOL: 1 -> 5 on dut1 after reset, then any request reports EOL
        run_req(1, 5, 1'b1, 1, 0);
        check("to_eol", int'(st1), 5);
        run_req(1, 0, 1'b1, 1, 10);
        check("eol_err", r_err, 3);
        check("eol_succ", r_succ, 0);
        check("eol_hold", r_hold_ok, 1);
        check("eol_state", int'(st1), 5);

        // Reset in READ with mem_valid pending
        sel = 0;
        @(negedge clk);
        req_target = 3'd2;
        req_id = gold(2);
        req0 = 1'b1;
        @(negedge clk);
        check("pre_rst_rden", int'(rd_en0), 1);
        mem_rd_data = gold(2);
        mem_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_rden", int'(rd_en0), 0);
        @(negedge clk);
        mem_valid = 1'b0;
        req0 = 1'b0;
        rst = 1'b0;
        check("arst_chg", int'(chg0), 0);
        check("arst_done", int'(done0), 0);
        check("arst_state", int'(st0), 1);
        repeat (3) begin
            @(negedge clk);
            if (chg0 || done0) check("arst_quiet", 1, 0);
        end
        check("arst_state_after", int'(st0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
